// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common-data-bus arbiter between the execution units and the
// ROB / reservation stations.
//
// Every producer channel owns a small result FIFO behind a valid/ready
// handshake. A round-robin scan picks up to NUM_BUS non-empty channels per
// cycle. Their heads are popped and registered onto the broadcast slots.
// A flush (mispredict rollback) or rst discards every pending and
// in-flight result.
//
// Optional feature macro: CDB_BYPASS_EN. When it is defined, an empty
// channel that is pushing this cycle joins the arbitration with its input
// result. If it is granted, the result skips the FIFO, giving 1-cycle
// latency.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   flush      rollback: empty all FIFOs and drop the broadcast slots
//   src_valid  per-channel result valid
//   src_ready  per-channel FIFO has room; low while rst is high
//   src_data   per-channel result data, slice [i*DATA_W +: DATA_W]
//   src_tag    per-channel destination ROB index, slice [i*TAG_W +: TAG_W]
//   cdb_valid  per-slot broadcast valid
//   cdb_data   per-slot broadcast data
//   cdb_tag    per-slot broadcast ROB index
//   cdb_src    per-slot producing channel
module cdb_arbiter #(
  parameter int NUM_SRC    = 3,
  parameter int NUM_BUS    = 1,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 2,
  localparam int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NUM_SRC-1:0]         src_valid,
  output logic [NUM_SRC-1:0]         src_ready,
  input  logic [NUM_SRC*DATA_W-1:0]  src_data,
  input  logic [NUM_SRC*TAG_W-1:0]   src_tag,
  output logic [NUM_BUS-1:0]         cdb_valid,
  output logic [NUM_BUS*DATA_W-1:0]  cdb_data,
  output logic [NUM_BUS*TAG_W-1:0]   cdb_tag,
  output logic [NUM_BUS*SRC_W-1:0]   cdb_src
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DATA_W + TAG_W;

  logic [ENT_W-1:0]   mem_q    [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q [NUM_SRC];
  logic [PTR_W-1:0]   rd_ptr_d [NUM_SRC];
  logic [PTR_W-1:0]   wr_ptr_q [NUM_SRC];
  logic [PTR_W-1:0]   wr_ptr_d [NUM_SRC];
  logic [CNT_W-1:0]   cnt_q    [NUM_SRC];
  logic [CNT_W-1:0]   cnt_d    [NUM_SRC];
  logic [SRC_W-1:0]   rr_q, rr_d;

  logic [NUM_SRC-1:0] push, nonempty, cand, grant, pop, fifo_wr;
  logic [ENT_W-1:0]   in_ent   [NUM_SRC];
  logic [ENT_W-1:0]   cand_ent [NUM_SRC];

  logic [NUM_BUS-1:0] slot_vld;
  logic [ENT_W-1:0]   slot_ent [NUM_BUS];
  logic [SRC_W-1:0]   slot_src [NUM_BUS];

  logic [NUM_BUS-1:0]        cdb_valid_q;
  logic [NUM_BUS*DATA_W-1:0] cdb_data_q;
  logic [NUM_BUS*TAG_W-1:0]  cdb_tag_q;
  logic [NUM_BUS*SRC_W-1:0]  cdb_src_q;

  // Channel front end: ready only looks at the stored count, never at a
  // same-cycle pop, so a full FIFO stays closed for the cycle it drains.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = !rst && (cnt_q[i] < CNT_W'(FIFO_DEPTH));
      push[i]      = src_valid[i] && src_ready[i];
      nonempty[i]  = (cnt_q[i] != '0);
      in_ent[i]    = {src_tag[i*TAG_W +: TAG_W], src_data[i*DATA_W +: DATA_W]};
`ifdef CDB_BYPASS_EN
      // A non-empty channel always offers its head so per-channel order holds.
      cand[i]      = nonempty[i] || push[i];
      cand_ent[i]  = nonempty[i] ? mem_q[i][rd_ptr_q[i]] : in_ent[i];
`else
      cand[i]      = nonempty[i];
      cand_ent[i]  = mem_q[i][rd_ptr_q[i]];
`endif
    end
  end

  // Round-robin scan starting at rr_q; the b-th hit in scan order takes slot b.
  always_comb begin
    int ng;
    int last;
    int idx;
    int nxt;
    ng       = 0;
    last     = 0;
    idx      = 0;
    nxt      = 0;
    grant    = '0;
    slot_vld = '0;
    rr_d     = rr_q;
    for (int b = 0; b < NUM_BUS; b++) begin
      slot_ent[b] = '0;
      slot_src[b] = '0;
    end
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (cand[idx] && (ng < NUM_BUS)) begin
        grant[idx]   = 1'b1;
        slot_vld[ng] = 1'b1;
        slot_ent[ng] = cand_ent[idx];
        slot_src[ng] = SRC_W'(idx);
        last         = idx;
        ng           = ng + 1;
      end
    end
    if (ng > 0) begin
      nxt = last + 1;
      if (nxt >= NUM_SRC) nxt = 0;
      rr_d = SRC_W'(nxt);
    end
  end

  // FIFO bookkeeping. A bypassed grant (empty channel) consumes the input
  // directly, so the FIFO is neither written nor popped for it.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      pop[i]     = grant[i] && nonempty[i];
      fifo_wr[i] = push[i] && !(grant[i] && !nonempty[i]);
      if (rst || flush) begin
        rd_ptr_d[i] = '0;
        wr_ptr_d[i] = '0;
        cnt_d[i]    = '0;
      end else begin
        rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop[i]);
        wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(fifo_wr[i]);
        cnt_d[i]    = cnt_q[i] + CNT_W'(fifo_wr[i]) - CNT_W'(pop[i]);
      end
    end
  end

  // Storage: data only, no reset; occupancy is tracked by the counters.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (fifo_wr[i] && !rst && !flush) mem_q[i][wr_ptr_q[i]] <= in_ent[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      rd_ptr_q[i] <= rd_ptr_d[i];
      wr_ptr_q[i] <= wr_ptr_d[i];
      cnt_q[i]    <= cnt_d[i];
    end
  end

  // Broadcast registers: idle slots keep their last payload, only valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q <= '0;
      cdb_data_q  <= '0;
      cdb_tag_q   <= '0;
      cdb_src_q   <= '0;
    end else if (flush) begin
      cdb_valid_q <= '0;
    end else begin
      cdb_valid_q <= slot_vld;
      for (int b = 0; b < NUM_BUS; b++) begin
        if (slot_vld[b]) begin
          cdb_data_q[b*DATA_W +: DATA_W] <= slot_ent[b][DATA_W-1:0];
          cdb_tag_q[b*TAG_W +: TAG_W]    <= slot_ent[b][DATA_W +: TAG_W];
          cdb_src_q[b*SRC_W +: SRC_W]    <= slot_src[b];
        end
      end
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_src   = cdb_src_q;

endmodule
